// File: rtl/tour_cmd_seq.sv
// rtl/tour_cmd_seq.sv - tour command sequencer: UART mux, stored-move replay, abort and optional watchdog
// Optional TOUR_TIMEOUT_EN adds a send_resp watchdog of TO_CYCLES clocks.
module tour_cmd_seq #(
    parameter int          NUM_MOVES = 24,
    parameter int          IDX_W     = $clog2(NUM_MOVES),
    parameter logic [3:0]  ABORT_OPC = 4'hF,
    parameter int          TO_CYCLES = 50_000_000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_tour,
    input  logic [7:0]       move,
    output logic [IDX_W-1:0] mv_indx,
    input  logic [15:0]      cmd_UART,
    input  logic             cmd_rdy_UART,
    input  logic             clr_cmd_rdy,
    input  logic             send_resp,
    output logic [15:0]      cmd,
    output logic             cmd_rdy,
    output logic [7:0]       resp,
    output logic             tour_busy,
    output logic             tour_err
);

    typedef enum logic [2:0] {IDLE, LD_V, WT_V, LD_H, WT_H} state_t;

    localparam logic [15:0] VERT [0:7] = '{16'h4002, 16'h4002, 16'h4001, 16'h47F1,
                                           16'h47F2, 16'h47F2, 16'h47F1, 16'h4001};
    localparam logic [15:0] HORZ [0:7] = '{16'h5BF1, 16'h53F1, 16'h53F2, 16'h53F2,
                                           16'h53F1, 16'h5BF1, 16'h5BF2, 16'h5BF2};

    state_t      state, nxt_state;
    logic [2:0]  sel;
    logic [15:0] vert, horz;
    logic        tour_rdy, last, abort, timeout, stop;

    assign last  = (mv_indx == IDX_W'(NUM_MOVES - 1));
    assign abort = (state != IDLE) && cmd_rdy_UART && (cmd_UART[15:12] == ABORT_OPC);
    assign stop  = abort || timeout;

`ifdef TOUR_TIMEOUT_EN
    logic [25:0] wd;
    logic        in_wt;

    assign in_wt   = (state == WT_V) || (state == WT_H);
    assign timeout = in_wt && (wd == 26'(TO_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            wd <= '0;
        else if (in_wt && !timeout)
            wd <= wd + 26'd1;
        else
            wd <= '0;
    end
`else
    // Parameter kept for interface compatibility; always false without the watchdog.
    assign timeout = (TO_CYCLES < 0);
`endif

    // Lowest set bit of the one-hot move selects the table entry.
    always_comb begin
        sel = 3'd0;
        casez (move)
            8'b???????1: sel = 3'd0;
            8'b??????10: sel = 3'd1;
            8'b?????100: sel = 3'd2;
            8'b????1000: sel = 3'd3;
            8'b???10000: sel = 3'd4;
            8'b??100000: sel = 3'd5;
            8'b?1000000: sel = 3'd6;
            8'b10000000: sel = 3'd7;
            default:     sel = 3'd0;
        endcase
        vert = (move == 8'h00) ? 16'h8000 : VERT[sel];
        horz = (move == 8'h00) ? 16'h8000 : HORZ[sel];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= nxt_state;
    end

    always_comb begin
        nxt_state = state;
        case (state)
            IDLE: if (start_tour)  nxt_state = LD_V;
            LD_V: if (clr_cmd_rdy) nxt_state = WT_V;
            WT_V: if (send_resp)   nxt_state = LD_H;
            LD_H: if (clr_cmd_rdy) nxt_state = WT_H;
            WT_H: if (send_resp)   nxt_state = last ? IDLE : LD_V;
            default:               nxt_state = IDLE;
        endcase
        if (stop)
            nxt_state = IDLE;
    end

    always_comb begin
        cmd       = cmd_UART;
        tour_rdy  = 1'b0;
        tour_busy = 1'b1;
        resp      = last ? 8'hA5 : 8'h5A;
        case (state)
            IDLE: begin
                tour_busy = 1'b0;
                resp      = tour_err ? 8'hC3 : 8'hA5;
            end
            LD_V: begin
                cmd      = vert;
                tour_rdy = !clr_cmd_rdy;
            end
            WT_V: cmd = vert;
            LD_H: begin
                cmd      = horz;
                tour_rdy = !clr_cmd_rdy;
            end
            WT_H: cmd = horz;
            default: ;
        endcase
    end

    // mv_indx is left untouched on abort so the failing move can be inspected.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mv_indx  <= '0;
            cmd_rdy  <= 1'b0;
            tour_err <= 1'b0;
        end else begin
            if (state == IDLE) begin
                cmd_rdy <= cmd_rdy_UART;
                if (start_tour) begin
                    mv_indx  <= '0;
                    tour_err <= 1'b0;
                end
            end else if (stop) begin
                cmd_rdy  <= 1'b0;
                tour_err <= 1'b1;
            end else begin
                cmd_rdy <= tour_rdy;
                if (state == WT_H && send_resp && !last)
                    mv_indx <= mv_indx + 1'b1;
            end
        end
    end

endmodule

// File: doc/tour_cmd_seq.md
Name: tour_cmd_seq

Overview:
Parametrised tour command sequencer between the UART wrapper, the tour-logic move store and cmd_proc. It muxes UART commands to cmd_proc while idle. On start_tour it replays NUM_MOVES stored moves, each as a vertical then a horizontal motion command with full cmd_rdy/clr_cmd_rdy/send_resp handshaking. Unlike the previous generation, it adds runtime abort from UART and a send_resp watchdog.

Parameters:
NUM_MOVES, 24, moves per tour (legal range 2..64); last index is NUM_MOVES-1
IDX_W, $clog2(NUM_MOVES), width of mv_indx
ABORT_OPC, 4'hF, cmd_UART[15:12] value that aborts a running tour
TO_CYCLES, 50_000_000, watchdog limit in clk cycles waiting for send_resp (TOUR_TIMEOUT_EN only)

Ports:
clk  in  1  system clock; all state on posedge
rst_n  in  1  asynchronous active-low reset
start_tour  in  1  pulse from tour logic: moves valid, begin replay
move  in  8  one-hot encoded move at mv_indx (combinational from store)
mv_indx  out  IDX_W  move store address
cmd_UART  in  16  command from UART wrapper
cmd_rdy_UART  in  1  UART command valid
clr_cmd_rdy  in  1  cmd_proc has consumed cmd
send_resp  in  1  cmd_proc finished the current command
cmd  out  16  muxed command to cmd_proc
cmd_rdy  out  1  registered command valid to cmd_proc
resp  out  8  status byte to UART
tour_busy  out  1  high in any non-IDLE state
tour_err  out  1  sticky; set on abort or timeout, cleared on next start_tour

Behaviour:
- Reset values: state=IDLE, mv_indx=0, cmd_rdy=0, tour_err=0, watchdog=0. Combinational outputs follow IDLE: cmd=cmd_UART, resp=8'hA5, tour_busy=0.
- States: IDLE, LD_V, WT_V, LD_H, WT_H.
- IDLE:
  - cmd=cmd_UART; cmd_rdy<=cmd_rdy_UART (one-cycle register latency).
  - start_tour: mv_indx<=0, tour_err<=0, go to LD_V. start_tour outside IDLE is ignored.
- LD_V / LD_H:
  - Tour cmd_rdy source=1.
  - clr_cmd_rdy: source=0 in the same cycle; go to WT_V / WT_H.
- WT_V: send_resp -> LD_H.
- WT_H, on send_resp:
  - mv_indx==NUM_MOVES-1: go to IDLE.
  - Otherwise: mv_indx<=mv_indx+1, go to LD_V.
- Outside IDLE: cmd_rdy<=tour source; cmd_rdy_UART is never forwarded.
- Encoding: lowest set bit of move wins. Entries are bit: vertical/horizontal.
  - 0: 4002/5BF1
  - 1: 4002/53F1
  - 2: 4001/53F2
  - 3: 47F1/53F2
  - 4: 47F2/53F1
  - 5: 47F2/5BF1
  - 6: 47F1/5BF2
  - 7: 4001/5BF2
  - move==0: cmd=16'h8000 in both phases.
  - Vertical entry applies in LD_V/WT_V; horizontal entry in LD_H/WT_H.
- resp:
  - IDLE: A5 if tour_err=0, else C3.
  - Non-IDLE: A5 when mv_indx==NUM_MOVES-1, else 5A.
- Abort:
  - Trigger: non-IDLE, cmd_rdy_UART=1 and cmd_UART[15:12]==ABORT_OPC.
  - Next cycle: state=IDLE, cmd_rdy=0, tour_err=1; mv_indx holds for debug.
  - Abort has priority over clr_cmd_rdy/send_resp in the same cycle.
  - The abort command itself is not forwarded to cmd_proc.
- Simultaneous clr_cmd_rdy and send_resp in LD_x: only clr_cmd_rdy is acted on.
- Reset mid-tour: immediate return to reset values. No resume.

Optional Feature:
TOUR_TIMEOUT_EN:
- Defined:
  - A 26-bit watchdog counts each cycle in WT_V/WT_H and clears on entering any other state.
  - Reaching TO_CYCLES-1 acts exactly as an abort (IDLE, tour_err=1, resp C3).
- Undefined: no watchdog; WT_x waits indefinitely, and tour_err is set only by UART abort.

Test Plan:
- Reset, then cmd_rdy_UART=1 with cmd_UART=16'h2345 -> cmd=2345, cmd_rdy=1 one cycle later, resp=A5, tour_busy=0.
- NUM_MOVES=24, start_tour, move=8'h01 for all indices, immediate handshakes -> cmd alternates 4002/5BF1. 48 cmd_rdy pulses occur, mv_indx steps 0..23, resp=5A until index 23, then A5. Returns to IDLE.
- move=8'h0C (bits 2,3) -> vertical cmd 4001, horizontal 53F2. move=0 -> 8000 in both phases.
- Mid-tour in WT_H at index 5, cmd_UART=16'hF000 with cmd_rdy_UART -> IDLE next cycle, tour_err=1, resp=C3, mv_indx=5, cmd_rdy never asserted for F000. A following start_tour clears tour_err.
- TOUR_TIMEOUT_EN with TO_CYCLES=100, withhold send_resp in WT_V -> abort at cycle 100, resp=C3.
- NUM_MOVES=8 (IDX_W=3), full tour -> ends after index 7, 16 commands. Assert rst_n low mid-tour -> all outputs at reset values asynchronously.
